// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. A mult/div captures its result
// into pending registers at start and commits it to HI/LO after a fixed countdown.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  function automatic logic [2*WIDTH-1:0] mul_s(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] ye;
    xe = {{WIDTH{x[WIDTH-1]}}, x};
    ye = {{WIDTH{y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [2*WIDTH-1:0] mul_u(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = {{WIDTH{1'b0}}, x};
    ye = {{WIDTH{1'b0}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}; most-negative / -1 would overflow, so it is pinned.
  function automatic logic [2*WIDTH-1:0] div_s(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] r;
    if (y == '0) begin
      q = '0;
      r = '0;
    end else if (x == MOST_NEG && y == '1) begin
      q = x;
      r = '0;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  function automatic logic [2*WIDTH-1:0] div_u(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    if (y == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [2*WIDTH-1:0] res;
  logic             is_md;

  always_comb begin
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    res       = '0;
    is_md     = 1'b0;

    if (busy_q) begin
      // Any start while busy, including the completion cycle, is dropped here.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          res       = mul_s(a, b);
          is_md     = 1'b1;
          cnt_d     = MULT_LOAD;
          pend_wr_d = 1'b1;
        end
        OP_MULTU: begin
          res       = mul_u(a, b);
          is_md     = 1'b1;
          cnt_d     = MULT_LOAD;
          pend_wr_d = 1'b1;
        end
        OP_DIV: begin
          res       = div_s(a, b);
          is_md     = 1'b1;
          cnt_d     = DIV_LOAD;
          pend_wr_d = (b != '0);
        end
        OP_DIVU: begin
          res       = div_u(a, b);
          is_md     = 1'b1;
          cnt_d     = DIV_LOAD;
          pend_wr_d = (b != '0);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
      if (is_md) begin
        busy_d    = 1'b1;
        pend_hi_d = res[2*WIDTH-1:WIDTH];
        pend_lo_d = res[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed and random ops, expected HI/LO queued at issue
// and compared by a monitor whenever done pulses.
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;
  logic [W-1:0]   m_hi, m_lo;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (y != 0) begin
        q = sx / sy;
        r = sx - q * sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd3: if (y != 0) begin
        p = ux / uy; m_lo = p[31:0];
        p = ux % uy; m_hi = p[31:0];
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after done rises.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int intr, input logic [2:0] iop, input logic [W-1:0] ia);
    int n;
    logic [W-1:0] oh, ol;
    n  = (o < 3'd2) ? MC : DC;
    oh = m_hi;
    ol = m_lo;
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    exp_q.push_back({m_hi, m_lo});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_hold", 64'(busy), 64'(1));
      chk("done_low_while_busy", 64'(done), 64'(0));
      chk("hilo_hold", {hi, lo}, {oh, ol});
      start = (i == intr);
      if (start) begin
        op = iop; a = ia; b = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_fall", 64'(busy), 64'(0));
    chk("done_pulse", 64'(done), 64'(1));
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x);
    start = 1'b1; op = o; a = x; b = $urandom;
    model(o, x, b);
    @(negedge clk);
    start = 1'b0;
    chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    chk("mt_busy", 64'(busy), 64'(0));
    chk("mt_done", 64'(done), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 64'(done), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hilo", {hi, lo}, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    int           sel, intr;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, -1, 3'd0, '0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, -1, 3'd0, '0);
    chk("multu_dir", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, '0);
    chk("div_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2, -1, 3'd0, '0);
    chk("divu_dir", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, '0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    run_mt(3'd4, 32'h11);
    run_mt(3'd5, 32'h22);
    run_op(3'd3, 32'h1234_5678, 32'd0, -1, 3'd0, '0);
    chk("divu_by_zero", {hi, lo}, 64'h0000_0011_0000_0022);

    run_mt(3'd4, 32'h1234);
    run_op(3'd0, 32'd6, 32'd7, 0, 3'd5, 32'h5);
    chk("mtlo_ignored", {hi, lo}, 64'd42);
    run_mt(3'd6, 32'hDEAD);
    run_mt(3'd7, 32'hBEEF);

    // Intruder on the completion edge is dropped; the next op starts one edge later.
    run_op(3'd0, 32'd100, 32'hFFFF_FFFF, MC - 1, 3'd4, 32'hCAFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'd0, '0);

    run_mt(3'd4, 32'hAAAA);
    run_mt(3'd5, 32'hBBBB);
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_hilo", {hi, lo}, 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DC + 2; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", 64'(done), 64'(0));
    end
    chk("hilo_after_reset", {hi, lo}, 64'(0));

    for (int k = 0; k < 40; k++) begin
      ro  = 3'($urandom_range(0, 7));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) ry = '0;
      else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 2) ry = 32'($urandom_range(1, 9));
      if (ro < 3'd4) begin
        intr = ($urandom_range(0, 1) == 0) ? -1
             : $urandom_range(0, ((ro < 3'd2) ? MC : DC) - 1);
        run_op(ro, rx, ry, intr, 3'($urandom_range(0, 7)), $urandom);
      end else begin
        run_mt(ro, rx);
      end
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
